ritc_vdd_servo: RTL

- Closed-loop controller for the RITC sampling-speed Vdd DAC.
- Counts rising edges of the RITC monitor/feedback signal over a fixed gate window and compares the count against a software target with a tolerance.
- Issues single-cycle VDD_INCR / VDD_DECR pulses to the downstream DAC loader, then waits for that serial load to complete and the analog to settle before measuring again.
- Sits directly upstream of the DAC serial loader, on the same CLK.

---
 rtl/ritc_servo_pkg.sv | 26 ++
 rtl/ritc_vdd_servo_if.sv | 27 ++
 rtl/ritc_fb_edge_counter.sv | 49 ++++
 rtl/ritc_vdd_servo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ritc_servo_pkg.sv
// Shared constants for the RITC Vdd servo and the DAC loader it feeds:
// state encoding, default timing values and the DAC word width.
package ritc_servo_pkg;

  localparam int DAC_BITS           = 12;
  localparam int GATE_CYCLES_DEF    = 65536;
  localparam int SETTLE_CYCLES_DEF  = 1024;
  localparam int HOLDOFF_CYCLES_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GATE    = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_ADJUST  = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;
  localparam logic [2:0] ST_SETTLE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_GATE    = ST_GATE,
    S_COMPARE = ST_COMPARE,
    S_ADJUST  = ST_ADJUST,
    S_HOLDOFF = ST_HOLDOFF,
    S_SETTLE  = ST_SETTLE
  } state_t;

endpackage

// File: rtl/ritc_vdd_servo_if.sv
// Control/status bundle of the Vdd servo; master = servo side, slave = the
// register block, feedback source and DAC loader around it.
interface ritc_vdd_servo_if #(
  parameter int COUNT_BITS = 16
);
  logic                                ENABLE;
  logic [COUNT_BITS-1:0]               TARGET;
  logic [COUNT_BITS-1:0]               TOLERANCE;
  logic                                FB_IN;
  logic [ritc_servo_pkg::DAC_BITS-1:0] VDD_I;
  logic                                DAC_BUSY;
  logic                                VDD_INCR;
  logic                                VDD_DECR;
  logic [COUNT_BITS-1:0]               COUNT_O;
  logic                                LOCKED;
  logic                                LIMIT;

  modport master (
    input  ENABLE, TARGET, TOLERANCE, FB_IN, VDD_I, DAC_BUSY,
    output VDD_INCR, VDD_DECR, COUNT_O, LOCKED, LIMIT
  );

  modport slave (
    output ENABLE, TARGET, TOLERANCE, FB_IN, VDD_I, DAC_BUSY,
    input  VDD_INCR, VDD_DECR, COUNT_O, LOCKED, LIMIT
  );
endinterface

// File: rtl/ritc_fb_edge_counter.sv
// Synchronizes the asynchronous RITC feedback, detects rising edges and
// counts them (saturating) while enabled; clear has priority.
module ritc_fb_edge_counter #(
  parameter int COUNT_BITS = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fb_in,
  input  logic                  clr,
  input  logic                  en,
  output logic [COUNT_BITS-1:0] count
);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  hist_q, hist_d;
  logic [COUNT_BITS-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sync1_d = fb_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && sync2_q && !hist_q && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ritc_vdd_servo.sv
// Closed-loop Vdd servo: gate-window edge count vs TARGET +/- TOLERANCE, one
// INCR/DECR pulse per miss, then holdoff and settle. Option: RITC_VDD_SERVO_AVG_EN.
module ritc_vdd_servo
  import ritc_servo_pkg::*;
#(
  parameter int GATE_CYCLES    = GATE_CYCLES_DEF,
  parameter int COUNT_BITS     = 16,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int LOCK_COUNT     = 4,
  parameter int VDD_MIN        = 0,
  parameter int VDD_MAX        = 4095
) (
  input logic              CLK,
  input logic              RST,
  ritc_vdd_servo_if.master bus
);

  localparam int TIMER_MAX = (GATE_CYCLES > SETTLE_CYCLES)
                           ? ((GATE_CYCLES > HOLDOFF_CYCLES) ? GATE_CYCLES : HOLDOFF_CYCLES)
                           : ((SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES);
  localparam int TIMER_W = $clog2(TIMER_MAX + 1);
  localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [DAC_BITS-1:0] VMIN = DAC_BITS'(VDD_MIN);
  localparam logic [DAC_BITS-1:0] VMAX = DAC_BITS'(VDD_MAX);

  typedef logic [COUNT_BITS-1:0] cnt_t;
  typedef logic [COUNT_BITS:0]   ext_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic               locked_q, locked_d;
  logic               limit_q, limit_d;
  logic               incr_q, incr_d;
  logic               decr_q, decr_d;
  cnt_t               count_o_q, count_o_d;

  cnt_t edge_count;
  cnt_t meas;
  logic hist_full;
  ext_t tgt_x, tol_x, meas_x, lo_x, hi_x;
  logic below, above;

  ritc_fb_edge_counter #(.COUNT_BITS(COUNT_BITS)) u_edge_counter (
    .CLK   (CLK),
    .RST   (RST),
    .fb_in (bus.FB_IN),
    .clr   (state_q != S_GATE),
    .en    (state_q == S_GATE),
    .count (edge_count)
  );

`ifdef RITC_VDD_SERVO_AVG_EN
  // Three previous gate counts; together with the gate just finished they form the mean.
  logic [2:0][COUNT_BITS-1:0] hist_q, hist_d;
  logic [1:0]                 fill_q, fill_d;
  logic [COUNT_BITS+1:0]      sum;

  assign sum       = {2'b00, edge_count} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
  assign meas      = sum[COUNT_BITS+1:2];
  assign hist_full = (fill_q == 2'd3);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if ((state_q == S_IDLE) || ((state_q == S_ADJUST) && (incr_q || decr_q))) begin
      hist_d = '0;
      fill_d = '0;
    end else if ((state_q == S_COMPARE) && bus.ENABLE) begin
      hist_d = {hist_q[1:0], edge_count};
      if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
    end
  end

  // NOTE: the history is tiny and must start empty, so it is reset like any other flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
`else
  assign meas      = edge_count;
  assign hist_full = 1'b1;
`endif

  // One extra bit keeps TARGET +/- TOLERANCE from wrapping before clamping.
  always_comb begin
    tgt_x  = {1'b0, bus.TARGET};
    tol_x  = {1'b0, bus.TOLERANCE};
    meas_x = {1'b0, meas};
    lo_x   = (tgt_x >= tol_x) ? (tgt_x - tol_x) : '0;
    hi_x   = tgt_x + tol_x;
    if (hi_x[COUNT_BITS]) hi_x = {1'b0, {COUNT_BITS{1'b1}}};
    below  = meas_x < lo_x;
    above  = meas_x > hi_x;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lock_d    = lock_q;
    locked_d  = locked_q;
    limit_d   = limit_q;
    incr_d    = 1'b0;
    decr_d    = 1'b0;
    count_o_d = count_o_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.ENABLE) state_d = S_GATE;
      end
      S_GATE: begin
        if (timer_q == TIMER_W'(GATE_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_COMPARE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COMPARE: begin
        count_o_d = meas;
        if (!below && !above) begin
          if (lock_q != LOCK_W'(LOCK_COUNT)) lock_d = lock_q + 1'b1;
          locked_d = (lock_d == LOCK_W'(LOCK_COUNT));
          limit_d  = 1'b0;
          state_d  = S_GATE;
        end else begin
          lock_d   = '0;
          locked_d = 1'b0;
          state_d  = S_GATE;
          if (hist_full) begin
            // Decide here so the pulse is registered and visible during ADJUST.
            state_d = S_ADJUST;
            if (below && (bus.VDD_I < VMAX)) begin
              incr_d  = 1'b1;
              limit_d = 1'b0;
            end else if (above && (bus.VDD_I > VMIN)) begin
              decr_d  = 1'b1;
              limit_d = 1'b0;
            end else begin
              limit_d = 1'b1;
            end
          end
        end
      end
      S_ADJUST: begin
        state_d = (incr_q || decr_q) ? S_HOLDOFF : S_GATE;
      end
      S_HOLDOFF: begin
        if (timer_q == TIMER_W'(HOLDOFF_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_SETTLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (bus.DAC_BUSY) begin
          timer_d = '0;
        end else if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_GATE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable wins over everything; the last measurement and LIMIT stay visible.
    if (!bus.ENABLE) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      lock_d    = '0;
      locked_d  = 1'b0;
      incr_d    = 1'b0;
      decr_d    = 1'b0;
      limit_d   = limit_q;
      count_o_d = count_o_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      lock_q    <= '0;
      locked_q  <= 1'b0;
      limit_q   <= 1'b0;
      incr_q    <= 1'b0;
      decr_q    <= 1'b0;
      count_o_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lock_q    <= lock_d;
      locked_q  <= locked_d;
      limit_q   <= limit_d;
      incr_q    <= incr_d;
      decr_q    <= decr_d;
      count_o_q <= count_o_d;
    end
  end

  assign bus.VDD_INCR = incr_q;
  assign bus.VDD_DECR = decr_q;
  assign bus.COUNT_O  = count_o_q;
  assign bus.LOCKED   = locked_q;
  assign bus.LIMIT    = limit_q;

endmodule
